// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 sensor emulator: state codes, default
// timing at 50 MHz and the frame checksum helper.
package dht11_pkg;

   // Default phase lengths in 50 MHz clock cycles
   localparam int unsigned DEF_START_MIN_CYC = 900000;
   localparam int unsigned DEF_RESP_WAIT_CYC = 1500;
   localparam int unsigned DEF_ACK_LOW_CYC   = 4000;
   localparam int unsigned DEF_ACK_HIGH_CYC  = 4000;
   localparam int unsigned DEF_BIT_LOW_CYC   = 2500;
   localparam int unsigned DEF_BIT0_HIGH_CYC = 1300;
   localparam int unsigned DEF_BIT1_HIGH_CYC = 3500;

   localparam int CNT_W      = 22;
   localparam int FRAME_BITS = 40;

   // Protocol states; WAIT_REL keeps its code but is never entered
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_HOST_LOW  = 4'd1;
   localparam logic [3:0] ST_WAIT_REL  = 4'd2;
   localparam logic [3:0] ST_RESP_WAIT = 4'd3;
   localparam logic [3:0] ST_ACK_LOW   = 4'd4;
   localparam logic [3:0] ST_ACK_HIGH  = 4'd5;
   localparam logic [3:0] ST_BIT_LOW   = 4'd6;
   localparam logic [3:0] ST_BIT_HIGH  = 4'd7;
   localparam logic [3:0] ST_END_LOW   = 4'd8;

   // Byte-sum checksum; the sum is carried in 10 bits and truncated
   function automatic logic [7:0] dht11_checksum(input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic [7:0] c,
                                                 input logic [7:0] d,
                                                 input logic       corrupt);
      logic [9:0] sum;
      sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
      return 8'(sum) ^ {8{corrupt}};
   endfunction

   // States in which the emulator pulls the line low
   function automatic logic drives_low(input logic [3:0] st);
      return (st == ST_ACK_LOW) || (st == ST_BIT_LOW) || (st == ST_END_LOW);
   endfunction

endpackage

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the raw data line; resets to the idle-high level
// so a reset never looks like a host start pulse.
module dht11_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Double-register the asynchronous pad level
   always_ff @(posedge clk) begin
      if (!rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dht11_emulator.sv
// DHT11 sensor-side emulator: detects the host start pulse, sends the
// acknowledge and shifts out a 40-bit frame with its checksum.
module dht11_emulator
   import dht11_pkg::*;
#(
   parameter int unsigned START_MIN_CYC = DEF_START_MIN_CYC,
   parameter int unsigned RESP_WAIT_CYC = DEF_RESP_WAIT_CYC,
   parameter int unsigned ACK_LOW_CYC   = DEF_ACK_LOW_CYC,
   parameter int unsigned ACK_HIGH_CYC  = DEF_ACK_HIGH_CYC,
   parameter int unsigned BIT_LOW_CYC   = DEF_BIT_LOW_CYC,
   parameter int unsigned BIT0_HIGH_CYC = DEF_BIT0_HIGH_CYC,
   parameter int unsigned BIT1_HIGH_CYC = DEF_BIT1_HIGH_CYC
) (
   input  logic       clk_50MHz,
   input  logic       rst,
   input  logic       en,
   input  logic       dht_in,
   output logic       dht_oe,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_float,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_float,
   input  logic       cs_corrupt,
   output logic       busy,
   output logic       done,
   output logic       short_start
);

   // The IDLE cycle that sees the first low sample is not counted, so the
   // accept threshold is one below the required number of low samples
   localparam logic [CNT_W-1:0] START_LAST = 22'(START_MIN_CYC - 1);
   localparam logic [CNT_W-1:0] START_SAT  = 22'(START_MIN_CYC);
   localparam logic [CNT_W-1:0] RESP_LAST  = 22'(RESP_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] ACKL_LAST  = 22'(ACK_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] ACKH_LAST  = 22'(ACK_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] BLOW_LAST  = 22'(BIT_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] BIT0_LAST  = 22'(BIT0_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] BIT1_LAST  = 22'(BIT1_HIGH_CYC - 1);

   logic                  s_in;
   logic [3:0]            state;
   logic [3:0]            state_next;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      phase_last;
   logic [5:0]            bit_idx;
   logic [FRAME_BITS-1:0] shift_reg;
   logic                  phase_done;
   logic                  start_ok;

   dht11_sync u_sync (
      .clk (clk_50MHz),
      .rst (rst),
      .d   (dht_in),
      .q   (s_in)
   );

   // Last counter value of the current timed phase
   always_comb begin
      phase_last = RESP_LAST;
      case (state)
         ST_RESP_WAIT: phase_last = RESP_LAST;
         ST_ACK_LOW:   phase_last = ACKL_LAST;
         ST_ACK_HIGH:  phase_last = ACKH_LAST;
         ST_BIT_LOW:   phase_last = BLOW_LAST;
         ST_BIT_HIGH:  phase_last = shift_reg[FRAME_BITS-1] ? BIT1_LAST : BIT0_LAST;
         ST_END_LOW:   phase_last = BLOW_LAST;
         default:      phase_last = RESP_LAST;
      endcase
   end

   assign phase_done = (cnt == phase_last);
   assign start_ok   = (cnt >= START_LAST);
   assign busy       = (state != ST_IDLE) && (state != ST_HOST_LOW);

   // Next-state decode; disable overrides everything
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:      if (!s_in) state_next = ST_HOST_LOW;
         ST_HOST_LOW:  if (s_in) state_next = start_ok ? ST_RESP_WAIT : ST_IDLE;
         ST_RESP_WAIT: if (phase_done) state_next = ST_ACK_LOW;
         ST_ACK_LOW:   if (phase_done) state_next = ST_ACK_HIGH;
         ST_ACK_HIGH:  if (phase_done) state_next = ST_BIT_LOW;
         ST_BIT_LOW:   if (phase_done) state_next = ST_BIT_HIGH;
         ST_BIT_HIGH:  if (phase_done)
                          state_next = (bit_idx == 6'd39) ? ST_END_LOW : ST_BIT_LOW;
         ST_END_LOW:   if (phase_done) state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
      if (!en) state_next = ST_IDLE;
   end

   // State, counters, frame shift register and registered line/pulse outputs
   always_ff @(posedge clk_50MHz) begin
      if (!rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         dht_oe      <= 1'b0;
         done        <= 1'b0;
         short_start <= 1'b0;
      end else begin
         state       <= state_next;
         dht_oe      <= drives_low(state_next);
         done        <= 1'b0;
         short_start <= 1'b0;
         if (!en) begin
            cnt     <= '0;
            bit_idx <= '0;
         end else begin
            case (state)
               ST_HOST_LOW: begin
                  if (s_in) begin
                     cnt <= '0;
                     if (start_ok)
                        shift_reg <= {hum_int, hum_float, temp_int, temp_float,
                                      dht11_checksum(hum_int, hum_float, temp_int,
                                                     temp_float, cs_corrupt)};
                     else
                        short_start <= 1'b1;
                  end else if (cnt < START_SAT) begin
                     cnt <= cnt + 22'd1;
                  end
               end
               ST_RESP_WAIT, ST_ACK_LOW, ST_ACK_HIGH,
               ST_BIT_LOW, ST_BIT_HIGH, ST_END_LOW: begin
                  if (phase_done) begin
                     cnt <= '0;
                     if (state == ST_ACK_HIGH) bit_idx <= '0;
                     if (state == ST_BIT_HIGH) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                        bit_idx   <= bit_idx + 6'd1;
                     end
                     if (state == ST_END_LOW) done <= 1'b1;
                  end else begin
                     cnt <= cnt + 22'd1;
                  end
               end
               default: cnt <= '0;
            endcase
         end
      end
   end

endmodule
